// File: rtl/serializer_pkg.sv
// Shared types and default sizing for the group serializer.
package serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_GROUP_SIZE  = 16;
  localparam int unsigned DEFAULT_COUNT_WIDTH = 5;

endpackage

// File: rtl/ser_hold_reg.sv
// One-word staging register with full flag, used by group_serializer when
// SERIALIZER_PRELOAD_EN is defined; absent from the default build.
`ifdef SERIALIZER_PRELOAD_EN
module ser_hold_reg
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_GROUP_SIZE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture,
  input  logic             take,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] word,
  output logic             full
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             full_q, full_d;

  always_comb begin
    word_d = word_q;
    full_d = full_q;
    if (capture) begin
      word_d = data_in;
      full_d = 1'b1;
    end else if (take) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      full_q <= full_d;
    end
  end

  assign word = word_q;
  assign full = full_q;

endmodule
`endif

// File: rtl/group_serializer.sv
// Parallel-to-serial word emitter, MSB first, with valid/advance handshake.
// Optional one-word preload buffer enabled by defining SERIALIZER_PRELOAD_EN.
module group_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned GROUP_SIZE  = DEFAULT_GROUP_SIZE,
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [GROUP_SIZE-1:0] groupedElements,
  output logic                  ready,
  output logic                  element,
  output logic                  elementValid,
  input  logic                  advance,
  output logic                  done
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(GROUP_SIZE - 1);

  state_t                  state_q, state_d;
  logic [GROUP_SIZE-1:0]   shift_q, shift_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic                    hold_full, hold_capture, hold_take;
  logic [GROUP_SIZE-1:0]   hold_word;

`ifdef SERIALIZER_PRELOAD_EN
  ser_hold_reg #(.WIDTH(GROUP_SIZE)) u_hold (
    .clock   (clock),
    .reset   (reset),
    .capture (hold_capture),
    .take    (hold_take),
    .data_in (groupedElements),
    .word    (hold_word),
    .full    (hold_full)
  );
  assign ready = !reset && !hold_full;
`else
  logic unused_hold;
  assign hold_full   = 1'b0;
  assign hold_word   = '0;
  assign unused_hold = hold_capture ^ hold_take;
  assign ready       = !reset && (state_q == IDLE);
`endif

  assign accept = load && ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    done_d       = 1'b0;
    hold_capture = 1'b0;
    hold_take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = groupedElements;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (advance) begin
          if (count_q == LAST_IDX) begin
            done_d = 1'b1;
            // Buffered word wins over a new offer; either way no idle bubble.
            if (hold_full) begin
              shift_d   = hold_word;
              count_d   = '0;
              hold_take = 1'b1;
            end else if (accept) begin
              shift_d = groupedElements;
              count_d = '0;
            end else begin
              shift_d = shift_q << 1;
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q << 1;
            count_d = count_q + 1'b1;
          end
        end
        hold_capture = accept && !(advance && (count_q == LAST_IDX));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Shifting fills zeros, so the MSB reads 0 once a word has fully drained.
  assign element      = shift_q[GROUP_SIZE-1];
  assign elementValid = (state_q == SEND);
  assign done         = done_q;

endmodule

// File: tb/tb_group_serializer.sv
// Scoreboard bench for group_serializer; word bits are queued on acceptance
// and compared as the consumer takes them.
module tb_group_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic        ready;
  logic        element;
  logic        elementValid;
  logic        advance = 1'b0;
  logic        done;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  group_serializer #(.GROUP_SIZE(16), .COUNT_WIDTH(5)) dut (
    .clock           (clk),
    .reset           (rst),
    .load            (load),
    .groupedElements (data),
    .ready           (ready),
    .element         (element),
    .elementValid    (elementValid),
    .advance         (advance),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic test_reset();
    logic exp_b;
    rst = 1'b1; load = 1'b0; advance = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ready); end
    checks++;
    if (elementValid !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rst_outputs got ev=%b done=%b exp 0/0", elementValid, done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1 || element !== 1'b0) begin
      failures++; $display("FAIL idle_outputs got ready=%b el=%b exp 1/0", ready, element);
    end
    // 16'hA5C3 with continuous advance
    push_word(16'hA5C3);
    load = 1'b1; data = 16'hA5C3; advance = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (elementValid !== 1'b1) begin failures++; $display("FAIL a5c3_valid bit=%0d got=%b exp=1", i, elementValid); end
      if (exp_q.size() == 0) begin
        checks++; failures++; $display("FAIL a5c3_underflow bit=%0d", i);
      end else begin
        exp_b = exp_q.pop_front();
        checks++;
        if (element !== exp_b) begin failures++; $display("FAIL a5c3_bit bit=%0d got=%b exp=%b", i, element, exp_b); end
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || ready !== 1'b1 || elementValid !== 1'b0) begin
      failures++; $display("FAIL a5c3_end got done=%b ready=%b ev=%b exp 1/1/0", done, ready, elementValid);
    end
    advance = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL a5c3_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_advance_toggle();
    int   dones = 0;
    logic exp_b;
    logic adv_now;
    push_word(16'h8001);
    load = 1'b1; data = 16'h8001; advance = 1'b0;
    tick();
    load = 1'b0;
    for (int cyc = 0; cyc < 64 && exp_q.size() > 0; cyc++) begin
      adv_now = (cyc % 2 == 0);
      advance = adv_now;
      checks++;
      if (elementValid !== 1'b1) begin failures++; $display("FAIL tog_valid cyc=%0d got=%b exp=1", cyc, elementValid); end
      if (adv_now) begin
        exp_b = exp_q.pop_front();
        checks++;
        if (element !== exp_b) begin failures++; $display("FAIL tog_bit cyc=%0d got=%b exp=%b", cyc, element, exp_b); end
      end
      tick();
      if (done === 1'b1) dones++;
    end
    advance = 1'b0;
    checks++;
    if (exp_q.size() != 0 || dones != 1) begin
      failures++; $display("FAIL tog_complete got left=%0d dones=%0d exp 0/1", exp_q.size(), dones);
    end
    tick();
    checks++;
    if (done !== 1'b0 || elementValid !== 1'b0) begin
      failures++; $display("FAIL tog_idle got done=%b ev=%b exp 0/0", done, elementValid);
    end
  endtask

`ifndef SERIALIZER_PRELOAD_EN
  task automatic test_load_ignored();
    logic exp_b;
    push_word(16'h1234);
    load = 1'b1; data = 16'h1234; advance = 1'b1;
    tick();
    for (int cyc = 0; cyc < 16; cyc++) begin
      load = (cyc < 3); data = 16'hFEDC;
      if (cyc < 3) begin
        checks++;
        if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready cyc=%0d got=%b exp=0", cyc, ready); end
      end
      exp_b = exp_q.pop_front();
      checks++;
      if (element !== exp_b || elementValid !== 1'b1) begin
        failures++; $display("FAIL busy_bit cyc=%0d got el=%b ev=%b exp el=%b ev=1", cyc, element, elementValid, exp_b);
      end
      tick();
    end
    load = 1'b0;
    checks++;
    if (done !== 1'b1 || elementValid !== 1'b0) begin
      failures++; $display("FAIL busy_end got done=%b ev=%b exp 1/0", done, elementValid);
    end
    push_word(16'hFEDC);
    load = 1'b1; data = 16'hFEDC;
    tick();
    load = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (element !== exp_b || elementValid !== 1'b1) begin
        failures++; $display("FAIL reoffer_bit cyc=%0d got el=%b ev=%b exp el=%b ev=1", cyc, element, elementValid, exp_b);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL reoffer_done got=%b exp=1", done); end
    advance = 1'b0;
    tick();
  endtask
`else
  task automatic test_back_to_back();
    logic [15:0] words [3];
    int   nxt = 0;
    int   valid_cycles = 0;
    int   dones = 0;
    int   third_cyc = -1;
    int   blocked = 0;
    logic exp_b;
    words[0] = 16'hFFFF; words[1] = 16'h0000; words[2] = 16'h5A5A;
    advance = 1'b1; load = 1'b1; data = words[0];
    for (int cyc = 0; cyc < 52; cyc++) begin
      if (elementValid === 1'b1) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_underflow cyc=%0d", cyc);
        end else begin
          exp_b = exp_q.pop_front();
          checks++;
          if (element !== exp_b) begin failures++; $display("FAIL b2b_bit cyc=%0d got=%b exp=%b", cyc, element, exp_b); end
        end
      end
      if (done === 1'b1) dones++;
      if (load && !ready && nxt == 2) blocked++;
      if (load && ready) begin
        push_word(words[nxt]);
        if (nxt == 2) third_cyc = cyc;
        nxt++;
      end
      if (nxt < 3) begin load = 1'b1; data = words[nxt]; end
      else load = 1'b0;
      tick();
    end
    advance = 1'b0;
    checks++;
    if (valid_cycles != 48) begin failures++; $display("FAIL b2b_valid_cycles got=%0d exp=48", valid_cycles); end
    checks++;
    if (dones != 3) begin failures++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
    checks++;
    if (third_cyc != 17 || blocked != 15) begin
      failures++; $display("FAIL b2b_third_load got cyc=%0d blocked=%0d exp 17/15", third_cyc, blocked);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
  endtask
`endif

  task automatic test_reset_midword();
    logic exp_b;
    push_word(16'hF0F0);
    load = 1'b1; data = 16'hF0F0; advance = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (element !== exp_b) begin failures++; $display("FAIL f0f0_bit bit=%0d got=%b exp=%b", i, element, exp_b); end
      tick();
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (elementValid !== 1'b0 || done !== 1'b0 || ready !== 1'b0 || element !== 1'b0) begin
      failures++; $display("FAIL midreset got ev=%b done=%b ready=%b el=%b exp 0/0/0/0", elementValid, done, ready, element);
    end
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b1 || elementValid !== 1'b0) begin
      failures++; $display("FAIL postreset got ready=%b ev=%b exp 1/0", ready, elementValid);
    end
    push_word(16'h0F0F);
    load = 1'b1; data = 16'h0F0F;
    tick();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_b = exp_q.pop_front();
      checks++;
      if (element !== exp_b || elementValid !== 1'b1) begin
        failures++; $display("FAIL 0f0f_bit bit=%0d got el=%b ev=%b exp el=%b ev=1", i, element, elementValid, exp_b);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL 0f0f_done got=%b exp=1", done); end
    advance = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_advance_toggle();
`ifndef SERIALIZER_PRELOAD_EN
    test_load_ignored();
`else
    test_back_to_back();
`endif
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
